// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, fixed latency,
// held response carrying read data or an error flag.
//
// state  | meaning
// S_IDLE | ready for a request; captures it on i_req_valid
// S_WAIT | latency countdown; request fields held in capture registers
// S_RESP | response held until i_resp_ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      acc_addr, acc_wdata, acc_off, acc_word, mem_word, mask32;
  logic             acc_ren, acc_wen, acc_err;
  logic [3:0]       acc_mask;
  logic [IDX_W-1:0] acc_idx;
  logic             go_resp, mem_we;

  // Fields used for the array access: with single-cycle latency the access
  // happens on the acceptance edge, so the live inputs are used directly.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = i_req_addr;
      acc_ren   = i_req_ren;
      acc_wen   = i_req_wen;
      acc_wdata = i_req_wdata;
      acc_mask  = i_req_mask;
    end else begin
      acc_addr  = addr_q;
      acc_ren   = ren_q;
      acc_wen   = wen_q;
      acc_wdata = wdata_q;
      acc_mask  = mask_q;
    end
    acc_off  = acc_addr - BASE_ADDR;
    acc_word = acc_off >> 2;
    acc_idx  = acc_word[IDX_W-1:0];
    acc_err  = (acc_ren == acc_wen) || (acc_addr[1:0] != 2'b00) ||
               (acc_mask == 4'b0000) || (acc_addr < BASE_ADDR) ||
               (acc_word >= 32'(DEPTH_WORDS));
    mem_word = mem_q[acc_idx];
    mask32   = {{8{acc_mask[3]}}, {8{acc_mask[2]}}, {8{acc_mask[1]}}, {8{acc_mask[0]}}};
  end

  // Next-state logic, request capture and response formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          ren_d   = i_req_ren;
          wen_d   = i_req_wen;
          wdata_d = i_req_wdata;
          mask_d  = i_req_mask;
          if (LATENCY == 1) begin
            go_resp = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 2);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          go_resp = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_ren && !acc_err) ? (mem_word & mask32) : 32'h0;
    end
    mem_we = go_resp && !acc_err && acc_wen;
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane array write; blocked by reset so an abandoned write never lands.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_resp_valid = (state_q == S_RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

endmodule
